cp0_intc: RTL and testbench
===========================

// Module: cp0_intc
// PURPOSE
//  Parametrised coprocessor-0 interrupt/exception controller.
//  Adds per-line edge/level mode, 2-flop input synchronisers, a global IE/EXL status with ERET return, vectored entry and W1C pending.
//  Sits beside the pipeline: commits only on PIPELINE_READY; drives redirect (S_INT, INT_ENTER) and return (EPC).
// PARAMETERS
//  N_INT        7             number of external interrupt lines, 1..16
//  ENTER_RESET  32'h0000_0080 reset value of vector base (INT_ENTER reg)
//  VEC_SHIFT    4             log2 byte spacing between interrupt vectors
// PORTS
//  CLK             in   1      clock, rising edge
//  RESETN          in   1      asynchronous active-low reset
//  PIPELINE_READY  in   1      commit strobe; all state updates gated by it
//  INT             in   N_INT  raw external interrupt lines, async
//  S_SYSCALL       in   1      syscall exception from pipeline
//  S_ERET          in   1      exception return from pipeline
//  EPC_IN          in   32     PC to save on entry
//  REG_R           in   6      CP0 register select
//  REG_WE          in   1      CP0 register write enable
//  REG_IN          in   32     CP0 write data
//  REG_OUT         out  32     CP0 read data, combinational on REG_R
//  S_INT           out  1      take exception/interrupt this cycle
//  INT_ENTER       out  32     target PC, valid when S_INT
//  EPC             out  32     saved return PC
// BEHAVIOUR
//  Reset (async, RESETN=0): sync flops, pending, mask, mode, IE, EXL, EPC, CAUSE = 0; base = ENTER_RESET.
//  Register map (REG_R):
//  - 0 STATUS   [0]=IE, [1]=EXL, [16+k]=MASK[k]
//  - 1 CAUSE    [6:2]=ExcCode (0 int, 8 syscall), [11:8]=taken line, [16+k]=PEND[k] (RO)
//  - 2 EPC; 3 BASE; 4 MODE ([k]=1 edge, 0 level); 5 PEND (W1C on edge lines)
//  - Other selects read 0, writes ignored; bits above N_INT read 0.
//  Input path: INT[k] -> 2-flop sync -> s[k]; edge = s[k] & ~s_d[k]; ~3 cycles pin to pending.
//  - Level line: PEND[k] = s[k] each cycle; W1C has no effect.
//  - Edge line: set on edge; cleared by entry on k or W1C; set beats clear same cycle.
//  - PEND updates every cycle, not gated by PIPELINE_READY.
//  Decision (combinational):
//  - avail = PEND & MASK; take_int = IE & ~EXL & |avail.
//  - Winner = lowest set index in avail.
//  - S_INT = S_SYSCALL | take_int.
//  - Syscall beats interrupt; losing interrupt stays pending.
//  - Syscall taken regardless of IE/EXL.
//  - INT_ENTER = BASE for syscall, else BASE + ((idx+1) << VEC_SHIFT), 32-bit wrap.
//  Entry (S_INT & PIPELINE_READY):
//  - EPC <= EPC_IN, EXL <= 1, ExcCode/idx updated, edge PEND[idx] cleared.
//  - Line idx reported as 0 for syscall.
//  Return: S_ERET & PIPELINE_READY & ~S_INT -> EXL <= 0; if S_INT also asserted, entry wins.
//  Software write (REG_WE & PIPELINE_READY): lands next edge; entry/ERET override same-cycle EPC/EXL writes.
//  Without PIPELINE_READY: S_INT/INT_ENTER still driven, no state changes, pending retained.
//  Reset mid-handler: EXL/IE cleared, pending lost.
// TESTING
//  T1 reset: RESETN=0 -> all REG_OUT reads 0 except BASE = 0x80; S_INT=0.
//  T2 edge int: MODE=1<<2, MASK=1<<2, IE=1; pulse INT[2] 1 cycle -> S_INT within 3 cycles.
//     Also INT_ENTER=0xB0; after READY, EPC=EPC_IN, EXL=1, PEND[2]=0.
//  T3 priority: edges on INT[5] and INT[1] same cycle, both masked in -> line 1 first.
//     After ERET, line 5 taken, INT_ENTER=0xE0.
//  T4 level: INT[3] held high, level mode -> retaken after ERET; PEND W1C no effect.
//     Drop INT[3] -> PEND[3]=0 after 3 cycles.
//  T5 syscall vs int: S_SYSCALL with INT[0] pending -> INT_ENTER=0x80, ExcCode=8, PEND[0] kept.
//  T6 stall: PIPELINE_READY=0 for 5 cycles with pending int -> EPC/EXL unchanged; commits on READY.

Source files
------------

// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: synchronised edge/level interrupt lines, IE/EXL status,
// vectored entry with EPC save, ERET return and software-visible CP0 registers.
module cp0_intc #(
  parameter int          N_INT       = 7,
  parameter logic [31:0] ENTER_RESET = 32'h0000_0080,
  parameter int          VEC_SHIFT   = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             PIPELINE_READY,
  input  logic [N_INT-1:0] INT,
  input  logic             S_SYSCALL,
  input  logic             S_ERET,
  input  logic [31:0]      EPC_IN,
  input  logic [5:0]       REG_R,
  input  logic             REG_WE,
  input  logic [31:0]      REG_IN,
  output logic [31:0]      REG_OUT,
  output logic             S_INT,
  output logic [31:0]      INT_ENTER,
  output logic [31:0]      EPC
);

  localparam logic [5:0] SEL_STATUS = 6'd0;
  localparam logic [5:0] SEL_CAUSE  = 6'd1;
  localparam logic [5:0] SEL_EPC    = 6'd2;
  localparam logic [5:0] SEL_BASE   = 6'd3;
  localparam logic [5:0] SEL_MODE   = 6'd4;
  localparam logic [5:0] SEL_PEND   = 6'd5;
  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;

  logic [N_INT-1:0] sync1_reg, sync2_reg, sync_d_reg;
  logic [N_INT-1:0] pend_reg, pend_next;
  logic [N_INT-1:0] mask_reg, mode_reg;
  logic [N_INT-1:0] edge_det, avail;
  logic             ie_reg, exl_reg;
  logic [31:0]      epc_reg, base_reg;
  logic [4:0]       exc_code_reg;
  logic [3:0]       line_reg;
  logic [3:0]       win_idx;
  logic             take_int, sw_we, w1c, int_entry;
  logic [15:0]      mask16, mode16, pend16;

  assign avail     = pend_reg & mask_reg;
  assign take_int  = ie_reg & ~exl_reg & (|avail);
  assign S_INT     = S_SYSCALL | take_int;
  assign int_entry = take_int & ~S_SYSCALL & PIPELINE_READY;
  assign sw_we     = REG_WE & PIPELINE_READY;
  assign w1c       = sw_we && (REG_R == SEL_PEND);
  assign EPC       = epc_reg;

  // Scan from the top down so the lowest pending index is the one left standing.
  always_comb begin
    win_idx = '0;
    for (int k = N_INT - 1; k >= 0; k--) begin
      if (avail[k]) win_idx = 4'(k);
    end
  end

  assign INT_ENTER = S_SYSCALL ? base_reg
                               : base_reg + ((32'(win_idx) + 32'd1) << VEC_SHIFT);

  // Edge lines hold until serviced or cleared; a fresh edge wins over a same-cycle clear.
  for (genvar gi = 0; gi < N_INT; gi++) begin : g_line
    logic line_clr;
    assign edge_det[gi]  = sync2_reg[gi] & ~sync_d_reg[gi];
    assign line_clr      = (int_entry && (win_idx == 4'(gi))) || (w1c && REG_IN[gi]);
    assign pend_next[gi] = mode_reg[gi] ? (edge_det[gi] | (pend_reg[gi] & ~line_clr))
                                        : sync2_reg[gi];
  end

  assign mask16 = 16'(mask_reg);
  assign mode16 = 16'(mode_reg);
  assign pend16 = 16'(pend_reg);

  always_comb begin
    REG_OUT = '0;
    case (REG_R)
      SEL_STATUS: REG_OUT = {mask16, 14'd0, exl_reg, ie_reg};
      SEL_CAUSE:  REG_OUT = {pend16, 4'd0, line_reg, 1'b0, exc_code_reg, 2'd0};
      SEL_EPC:    REG_OUT = epc_reg;
      SEL_BASE:   REG_OUT = base_reg;
      SEL_MODE:   REG_OUT = {16'd0, mode16};
      SEL_PEND:   REG_OUT = {16'd0, pend16};
      default:    REG_OUT = '0;
    endcase
  end

  // Pending and synchronisers run every cycle; architectural state waits for PIPELINE_READY.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      sync_d_reg <= '0;
      pend_reg   <= '0;
    end else begin
      sync1_reg  <= INT;
      sync2_reg  <= sync1_reg;
      sync_d_reg <= sync2_reg;
      pend_reg   <= pend_next;
    end
  end

  // CAUSE is read-only to software; entry and ERET are written last so they beat a same-cycle write.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mask_reg     <= '0;
      mode_reg     <= '0;
      ie_reg       <= 1'b0;
      exl_reg      <= 1'b0;
      epc_reg      <= '0;
      base_reg     <= ENTER_RESET;
      exc_code_reg <= '0;
      line_reg     <= '0;
    end else if (PIPELINE_READY) begin
      if (REG_WE) begin
        case (REG_R)
          SEL_STATUS: begin
            ie_reg   <= REG_IN[0];
            exl_reg  <= REG_IN[1];
            mask_reg <= REG_IN[16 +: N_INT];
          end
          SEL_EPC:  epc_reg  <= REG_IN;
          SEL_BASE: base_reg <= REG_IN;
          SEL_MODE: mode_reg <= REG_IN[N_INT-1:0];
          default:  ;
        endcase
      end
      if (S_INT) begin
        epc_reg      <= EPC_IN;
        exl_reg      <= 1'b1;
        exc_code_reg <= S_SYSCALL ? EXC_SYS : EXC_INT;
        line_reg     <= S_SYSCALL ? 4'd0 : win_idx;
      end else if (S_ERET) begin
        exl_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: reset state, edge/level interrupts, priority, syscall, stall, W1C.
module tb_cp0_intc;
  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        PIPELINE_READY = 1'b0;
  logic [6:0]  INT = '0;
  logic        S_SYSCALL = 1'b0;
  logic        S_ERET = 1'b0;
  logic [31:0] EPC_IN = '0;
  logic [5:0]  REG_R = '0;
  logic        REG_WE = 1'b0;
  logic [31:0] REG_IN = '0;
  logic [31:0] REG_OUT, INT_ENTER, EPC;
  logic        S_INT;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_intc #(.N_INT(7), .ENTER_RESET(32'h0000_0080), .VEC_SHIFT(4)) dut (
    .CLK(CLK), .RESETN(RESETN), .PIPELINE_READY(PIPELINE_READY), .INT(INT),
    .S_SYSCALL(S_SYSCALL), .S_ERET(S_ERET), .EPC_IN(EPC_IN), .REG_R(REG_R),
    .REG_WE(REG_WE), .REG_IN(REG_IN), .REG_OUT(REG_OUT), .S_INT(S_INT),
    .INT_ENTER(INT_ENTER), .EPC(EPC)
  );

  always #5 CLK = ~CLK;

  task automatic rd(input logic [5:0] sel, output logic [31:0] v);
    REG_R = sel; #1; v = REG_OUT;
  endtask

  task automatic wr(input logic [5:0] sel, input logic [31:0] data);
    REG_R = sel; REG_IN = data; REG_WE = 1'b1; PIPELINE_READY = 1'b1;
    @(negedge CLK);
    REG_WE = 1'b0; PIPELINE_READY = 1'b0; #1;
  endtask

  task automatic commit();
    PIPELINE_READY = 1'b1;
    @(negedge CLK);
    PIPELINE_READY = 1'b0; #1;
  endtask

  task automatic eret();
    S_ERET = 1'b1; commit(); S_ERET = 1'b0; #1;
  endtask

  task automatic pulse(input logic [6:0] lines);
    INT = lines; @(negedge CLK); INT = '0;
  endtask

  task automatic wait_sint(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget && cycles < 0; i++) begin
      @(negedge CLK); #1;
      if (S_INT === 1'b1) cycles = i;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_tab [0:6];
    logic [5:0]  sel_tab [0:6];
    sel_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9};
    exp_tab = '{32'h0, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0};
    RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 7; i++) begin
      rd(sel_tab[i], v);
      n_cmp++; if (v !== exp_tab[i]) begin n_bad++; $display("FAIL reset_reg%0d: got %h want %h", sel_tab[i], v, exp_tab[i]); end
    end
    n_cmp++; if (S_INT !== 1'b0) begin n_bad++; $display("FAIL reset_sint: got %b want 0", S_INT); end
    RESETN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_edge_int();
    logic [31:0] v;
    int c;
    wr(6'd4, 32'h0000_0004);
    wr(6'd0, 32'h0004_0001);
    pulse(7'h04);
    wait_sint(3, c);
    n_cmp++; if (c < 0) begin n_bad++; $display("FAIL edge_latency: got no S_INT want within 3 cycles"); end
    n_cmp++; if (INT_ENTER !== 32'hB0) begin n_bad++; $display("FAIL edge_enter: got %h want b0", INT_ENTER); end
    rd(6'd1, v);
    n_cmp++; if (v !== 32'h0004_0000) begin n_bad++; $display("FAIL edge_cause_pre: got %h want 00040000", v); end
    EPC_IN = 32'h0000_1000;
    commit();
    n_cmp++; if (EPC !== 32'h1000) begin n_bad++; $display("FAIL edge_epc: got %h want 1000", EPC); end
    rd(6'd0, v);
    n_cmp++; if (v !== 32'h0004_0003) begin n_bad++; $display("FAIL edge_status: got %h want 00040003", v); end
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL edge_pend_clr: got %h want 0", v); end
    rd(6'd1, v);
    n_cmp++; if (v !== 32'h0000_0200) begin n_bad++; $display("FAIL edge_cause_post: got %h want 00000200", v); end
    n_cmp++; if (S_INT !== 1'b0) begin n_bad++; $display("FAIL edge_exl_block: got %b want 0", S_INT); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    wr(6'd4, 32'h0000_0026);
    wr(6'd0, 32'h0022_0003);
    pulse(7'h22);
    repeat (3) @(negedge CLK);
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h22) begin n_bad++; $display("FAIL prio_pend: got %h want 22", v); end
    n_cmp++; if (S_INT !== 1'b0) begin n_bad++; $display("FAIL prio_exl_block: got %b want 0", S_INT); end
    eret();
    n_cmp++; if (S_INT !== 1'b1 || INT_ENTER !== 32'hA0) begin n_bad++; $display("FAIL prio_first: got %b/%h want 1/a0", S_INT, INT_ENTER); end
    EPC_IN = 32'h0000_2000;
    commit();
    rd(6'd1, v);
    n_cmp++; if (v !== 32'h0020_0100) begin n_bad++; $display("FAIL prio_cause1: got %h want 00200100", v); end
    eret();
    n_cmp++; if (S_INT !== 1'b1 || INT_ENTER !== 32'hE0) begin n_bad++; $display("FAIL prio_second: got %b/%h want 1/e0", S_INT, INT_ENTER); end
    EPC_IN = 32'h0000_3000;
    commit();
    rd(6'd1, v);
    n_cmp++; if (v !== 32'h0000_0500) begin n_bad++; $display("FAIL prio_cause5: got %h want 00000500", v); end
    eret();
    n_cmp++; if (S_INT !== 1'b0) begin n_bad++; $display("FAIL prio_idle: got %b want 0", S_INT); end
  endtask

  task automatic test_level();
    logic [31:0] v;
    int c;
    wr(6'd0, 32'h0008_0001);
    INT = 7'h08;
    wait_sint(4, c);
    n_cmp++; if (c < 0 || INT_ENTER !== 32'hC0) begin n_bad++; $display("FAIL level_take: got %0d/%h want >=0/c0", c, INT_ENTER); end
    EPC_IN = 32'h0000_4000;
    commit();
    wr(6'd5, 32'h0000_0008);
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h08) begin n_bad++; $display("FAIL level_w1c: got %h want 08", v); end
    eret();
    n_cmp++; if (S_INT !== 1'b1 || INT_ENTER !== 32'hC0) begin n_bad++; $display("FAIL level_retake: got %b/%h want 1/c0", S_INT, INT_ENTER); end
    commit();
    INT = 7'h00;
    repeat (3) @(negedge CLK);
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL level_drop: got %h want 0", v); end
    eret();
    n_cmp++; if (S_INT !== 1'b0) begin n_bad++; $display("FAIL level_idle: got %b want 0", S_INT); end
  endtask

  task automatic test_syscall();
    logic [31:0] v;
    int c;
    wr(6'd4, 32'h0000_0027);
    wr(6'd0, 32'h0001_0001);
    pulse(7'h01);
    wait_sint(3, c);
    n_cmp++; if (c < 0 || INT_ENTER !== 32'h90) begin n_bad++; $display("FAIL sys_int0: got %0d/%h want >=0/90", c, INT_ENTER); end
    S_SYSCALL = 1'b1; #1;
    n_cmp++; if (S_INT !== 1'b1 || INT_ENTER !== 32'h80) begin n_bad++; $display("FAIL sys_enter: got %b/%h want 1/80", S_INT, INT_ENTER); end
    EPC_IN = 32'h0000_5000;
    commit();
    S_SYSCALL = 1'b0;
    rd(6'd1, v);
    n_cmp++; if (v !== 32'h0001_0020) begin n_bad++; $display("FAIL sys_cause: got %h want 00010020", v); end
    rd(6'd0, v);
    n_cmp++; if (v !== 32'h0001_0003) begin n_bad++; $display("FAIL sys_status: got %h want 00010003", v); end
    eret();
    n_cmp++; if (S_INT !== 1'b1 || INT_ENTER !== 32'h90) begin n_bad++; $display("FAIL sys_then_int: got %b/%h want 1/90", S_INT, INT_ENTER); end
    EPC_IN = 32'h0000_6000;
    commit();
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL sys_pend_clr: got %h want 0", v); end
    eret();
  endtask

  task automatic test_stall();
    logic [31:0] v;
    int c;
    pulse(7'h01);
    wait_sint(3, c);
    n_cmp++; if (c < 0) begin n_bad++; $display("FAIL stall_take: got no S_INT want 1"); end
    EPC_IN = 32'h0000_7000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      rd(6'd0, v);
      n_cmp++; if (S_INT !== 1'b1 || EPC !== 32'h6000 || v !== 32'h0001_0001) begin
        n_bad++; $display("FAIL stall_hold%0d: got %b/%h/%h want 1/6000/00010001", i, S_INT, EPC, v);
      end
    end
    commit();
    rd(6'd0, v);
    n_cmp++; if (EPC !== 32'h7000 || v !== 32'h0001_0003) begin n_bad++; $display("FAIL stall_commit: got %h/%h want 7000/00010003", EPC, v); end
    pulse(7'h01);
    repeat (3) @(negedge CLK);
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL w1c_set: got %h want 1", v); end
    wr(6'd5, 32'h0000_0001);
    rd(6'd5, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL w1c_clear: got %h want 0", v); end
    eret();
    n_cmp++; if (S_INT !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got %b want 0", S_INT); end
  endtask

  initial begin
    test_reset();
    test_edge_int();
    test_priority();
    test_level();
    test_syscall();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
